// File: rtl/usb_ep0_pkg.sv
// usb_ep0_pkg: shared types and constants for the EP0 control-endpoint blocks
//    hs_t       : handshake codes returned to the usb core
//    state_t    : IN data-stage transmitter states
//    MAX_PKT_DEF: default EP0 max packet size
//    DESC_*     : descriptor type codes
package usb_ep0_pkg;
   typedef enum logic [1:0] {
      hs_ack   = 2'b00,
      hs_none  = 2'b01,
      hs_nak   = 2'b10,
      hs_stall = 2'b11
   } hs_t;
   typedef enum logic [2:0] {IDLE, ARMED, FETCH, SEND, WAIT_END, DONE} state_t;
   localparam int MAX_PKT_DEF = 64;
   localparam logic [7:0] DESC_DEVICE = 8'h01;
   localparam logic [7:0] DESC_CONFIG = 8'h02;
endpackage

// File: rtl/usb_ep0_in_tx_if.sv
// usb_ep0_in_tx_if: transaction bus between the usb core and the EP0 IN transmitter
//    core -> tx : transaction_active, endpoint, direction_in, setup, data_strobe, success
//    tx -> core : data_in, data_in_valid, data_toggle, handshake
//    master = usb core side, slave = transmitter side
interface usb_ep0_in_tx_if;
   import usb_ep0_pkg::*;
   logic       transaction_active;
   logic [3:0] endpoint;
   logic       direction_in;
   logic       setup;
   logic       data_strobe;
   logic       success;
   logic [7:0] data_in;
   logic       data_in_valid;
   logic       data_toggle;
   hs_t        handshake;
   modport master (
      output transaction_active, endpoint, direction_in, setup, data_strobe, success,
      input  data_in, data_in_valid, data_toggle, handshake
   );
   modport slave (
      input  transaction_active, endpoint, direction_in, setup, data_strobe, success,
      output data_in, data_in_valid, data_toggle, handshake
   );
endinterface

// File: rtl/usb_ep0_in_tx.sv
// usb_ep0_in_tx: EP0 IN data-stage transmitter streaming a descriptor ROM into the usb core
//    clk48mhz, rst (async, active high)
//    start/base_addr/desc_len/req_len : begin a data stage, abort : drop it
//    rom_addr/rom_data                : ROM port, data valid one cycle after the address
//    bus (slave)                      : core transaction signals and byte/toggle/handshake back
//    busy, done                       : stage in progress, one-cycle completion pulse
//    retry_cnt                        : un-ACKed packet count, only with USB_EP0_TX_RETRY_CNT_EN
module usb_ep0_in_tx
   import usb_ep0_pkg::*;
#(
   parameter int MAX_PKT = MAX_PKT_DEF,
   parameter int ADDR_W  = 8
) (
   input  logic              clk48mhz,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [15:0]       desc_len,
   input  logic [15:0]       req_len,
   input  logic              abort,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        rom_data,
   usb_ep0_in_tx_if.slave    bus,
   output logic              busy,
   output logic              done
`ifdef USB_EP0_TX_RETRY_CNT_EN
   ,
   output logic [7:0]        retry_cnt
`endif
);
   state_t            state;
   logic [ADDR_W-1:0] base_r;
   logic [15:0]       total, req_r, offset, cnt, rem, pkt, next_off;
   logic              ta_d, ds_d, succ_seen, toggle, valid;
   logic [7:0]        data_r;
   hs_t               hs;
   logic              ta_rise, ta_fall, ds_rise, ok, trig, last;

   assign rem      = total - offset;
   assign pkt      = (rem < 16'(MAX_PKT)) ? rem : 16'(MAX_PKT);
   assign next_off = offset + pkt;
   assign last     = (next_off == total) && (pkt < 16'(MAX_PKT) || total == req_r);
   assign ta_rise  = bus.transaction_active & ~ta_d;
   assign ta_fall  = ~bus.transaction_active & ta_d;
   assign ds_rise  = bus.data_strobe & ~ds_d;
   assign ok       = succ_seen | bus.success;
   assign trig     = ta_rise && bus.endpoint == 4'd0 && bus.direction_in && !bus.setup;
   // Address is presented combinationally in the cycle the fetch is decided (ARMED trigger or
   // SEND strobe) so a registered ROM returns the byte exactly when FETCH captures it.
   // cnt is held at zero in ARMED, and in SEND points at the byte being sent, hence the +1.
   assign rom_addr = base_r + offset[ADDR_W-1:0] + cnt[ADDR_W-1:0] + ADDR_W'(state == SEND);

   assign bus.data_in       = data_r;
   assign bus.data_in_valid = valid;
   assign bus.data_toggle   = toggle & (state != IDLE);
   assign bus.handshake     = hs;

   always_ff @(posedge clk48mhz or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         base_r    <= '0;
         total     <= '0;
         req_r     <= '0;
         offset    <= '0;
         cnt       <= '0;
         ta_d      <= 1'b0;
         ds_d      <= 1'b0;
         succ_seen <= 1'b0;
         toggle    <= 1'b0;
         valid     <= 1'b0;
         data_r    <= '0;
         hs        <= hs_nak;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         ta_d <= bus.transaction_active;
         ds_d <= bus.data_strobe;
         done <= 1'b0;
         if (state != IDLE && bus.success) succ_seen <= 1'b1;
         if (abort) begin
            state <= IDLE;
            valid <= 1'b0;
            busy  <= 1'b0;
            hs    <= hs_nak;
         end else if (start) begin
            total  <= (desc_len < req_len) ? desc_len : req_len;
            req_r  <= req_len;
            base_r <= base_addr;
            offset <= '0;
            cnt    <= '0;
            toggle <= 1'b1;
            valid  <= 1'b0;
            busy   <= 1'b1;
            hs     <= hs_ack;
            state  <= ARMED;
         end else begin
            case (state)
               ARMED: if (trig) begin
                  succ_seen <= 1'b0;
                  state     <= (pkt == 16'd0) ? WAIT_END : FETCH;
               end
               FETCH: if (ta_fall) begin
                  valid <= 1'b0;
                  cnt   <= '0;
                  state <= ARMED;
               end else begin
                  data_r <= rom_data;
                  valid  <= 1'b1;
                  state  <= SEND;
               end
               SEND: if (ta_fall) begin
                  valid <= 1'b0;
                  cnt   <= '0;
                  state <= ARMED;
               end else if (ds_rise) begin
                  cnt <= cnt + 16'd1;
                  if (cnt + 16'd1 == pkt) begin
                     valid <= 1'b0;
                     state <= WAIT_END;
                  end else state <= FETCH;
               end
               WAIT_END: if (ta_fall) begin
                  cnt <= '0;
                  if (ok) begin
                     offset <= next_off;
                     toggle <= ~toggle;
                     done   <= last;
                     state  <= last ? DONE : ARMED;
                  end else state <= ARMED;
               end
               DONE: begin
                  busy  <= 1'b0;
                  hs    <= hs_nak;
                  state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef USB_EP0_TX_RETRY_CNT_EN
   logic miss;
   // Same conditions under which the FSM takes the no-success exit (host timeout included).
   assign miss = !abort && !start && ta_fall &&
                 (state == FETCH || state == SEND || (state == WAIT_END && !ok));

   always_ff @(posedge clk48mhz or posedge rst) begin
      if (rst) retry_cnt <= '0;
      else if (start) retry_cnt <= '0;
      else if (miss && retry_cnt != 8'hff) retry_cnt <= retry_cnt + 8'd1;
   end
`endif
endmodule

// File: tb/tb_usb_ep0_in_tx.sv
// tb_usb_ep0_in_tx: directed self-checking bench for usb_ep0_in_tx with a registered ROM model
module tb_usb_ep0_in_tx;
   import usb_ep0_pkg::*;
   logic        clk = 1'b0;
   logic        rst, start, abort;
   logic [7:0]  base_addr, rom_addr, rom_data;
   logic [15:0] desc_len, req_len;
   logic        busy, done;
`ifdef USB_EP0_TX_RETRY_CNT_EN
   logic [7:0]  retry_cnt;
`endif
   int n_chk = 0, n_pass = 0, n_fail = 0;

   usb_ep0_in_tx_if bus();

   usb_ep0_in_tx dut (
      .clk48mhz (clk),
      .rst      (rst),
      .start    (start),
      .base_addr(base_addr),
      .desc_len (desc_len),
      .req_len  (req_len),
      .abort    (abort),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .bus      (bus),
      .busy     (busy),
      .done     (done)
`ifdef USB_EP0_TX_RETRY_CNT_EN
      ,
      .retry_cnt(retry_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rom_val(input logic [7:0] a);
      return (a * 8'd3) ^ 8'hA5;
   endfunction

   always @(posedge clk) rom_data <= rom_val(rom_addr);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic begin_stage(input logic [7:0] b, input logic [15:0] dl, input logic [15:0] rl);
      base_addr = b;
      desc_len  = dl;
      req_len   = rl;
      start     = 1'b1;
      tick();
      start = 1'b0;
      chk("armed_busy", busy, 1);
      chk("armed_hs", bus.handshake, hs_ack);
   endtask

   // Waits for a byte, checks it against the ROM model, then strobes it away.
   task automatic byte_step(input logic [7:0] a, input logic tog);
      int w = 0;
      while (!bus.data_in_valid && w < 10) begin
         tick();
         w++;
      end
      chk("byte_valid", bus.data_in_valid, 1);
      chk("byte_data", bus.data_in, rom_val(a));
      chk("byte_toggle", bus.data_toggle, tog);
      bus.data_strobe = 1'b1;
      tick();
      bus.data_strobe = 1'b0;
      tick();
   endtask

   task automatic in_xfer(input logic [7:0] a0, input int n, input bit ack, input logic tog,
                          input bit fin);
      bus.endpoint           = 4'd0;
      bus.direction_in       = 1'b1;
      bus.setup              = 1'b0;
      bus.transaction_active = 1'b1;
      if (n == 0) begin
         repeat (3) tick();
         chk("zlp_valid", bus.data_in_valid, 0);
         chk("zlp_toggle", bus.data_toggle, tog);
      end
      for (int i = 0; i < n; i++) byte_step(a0 + 8'(i), tog);
      tick();
      chk("end_valid", bus.data_in_valid, 0);
      bus.success = ack;
      tick();
      bus.success            = 1'b0;
      bus.transaction_active = 1'b0;
      tick();
      chk("done", done, fin);
      tick();
      chk("busy_after", busy, !fin);
      chk("hs_after", bus.handshake, fin ? hs_nak : hs_ack);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      base_addr = '0; desc_len = '0; req_len = '0;
      bus.transaction_active = 1'b0; bus.endpoint = '0; bus.direction_in = 1'b0;
      bus.setup = 1'b0; bus.data_strobe = 1'b0; bus.success = 1'b0;
      #3;
      chk("rst_data", bus.data_in, 0);
      chk("rst_valid", bus.data_in_valid, 0);
      chk("rst_toggle", bus.data_toggle, 0);
      chk("rst_hs", bus.handshake, hs_nak);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_addr", rom_addr, 0);
      tick();
      rst = 1'b0;
      tick();
      // IN in IDLE is ignored
      bus.direction_in = 1'b1;
      bus.transaction_active = 1'b1;
      repeat (4) tick();
      chk("idle_valid", bus.data_in_valid, 0);
      chk("idle_hs", bus.handshake, hs_nak);
      bus.transaction_active = 1'b0;
      tick();
      // 18-byte descriptor, one packet
      begin_stage(8'h10, 16'd18, 16'd64);
      chk("start_toggle", bus.data_toggle, 1);
      in_xfer(8'h10, 18, 1, 1'b1, 1);
      chk("idle_toggle", bus.data_toggle, 0);
      // clipped by wLength
      begin_stage(8'h10, 16'd18, 16'd8);
      in_xfer(8'h10, 8, 1, 1'b1, 1);
      // two full packets plus ZLP, address wraps past 0xFF
      begin_stage(8'hF0, 16'd128, 16'd255);
      in_xfer(8'hF0, 64, 1, 1'b1, 0);
      in_xfer(8'h30, 64, 1, 1'b0, 0);
      in_xfer(8'h70, 0, 1, 1'b1, 1);
      // retry after missing ACK
      begin_stage(8'h40, 16'd9, 16'd64);
      in_xfer(8'h40, 9, 0, 1'b1, 0);
`ifdef USB_EP0_TX_RETRY_CNT_EN
      chk("retry_one", retry_cnt, 1);
`endif
      in_xfer(8'h40, 9, 1, 1'b1, 1);
      // other endpoint ignored while ARMED
      begin_stage(8'h80, 16'd5, 16'd64);
`ifdef USB_EP0_TX_RETRY_CNT_EN
      chk("retry_clr", retry_cnt, 0);
`endif
      bus.endpoint = 4'd1;
      bus.transaction_active = 1'b1;
      repeat (4) tick();
      chk("ep1_valid", bus.data_in_valid, 0);
      chk("ep1_busy", busy, 1);
      chk("ep1_hs", bus.handshake, hs_ack);
      bus.transaction_active = 1'b0;
      tick();
      in_xfer(8'h80, 5, 1, 1'b1, 1);
      // abort after third strobe of a 64-byte packet
      begin_stage(8'h20, 16'd64, 16'd64);
      bus.endpoint = 4'd0;
      bus.transaction_active = 1'b1;
      for (int i = 0; i < 3; i++) byte_step(8'h20 + 8'(i), 1'b1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_valid", bus.data_in_valid, 0);
      chk("abort_busy", busy, 0);
      chk("abort_hs", bus.handshake, hs_nak);
      chk("abort_done", done, 0);
      tick();
      chk("abort_done2", done, 0);
      bus.transaction_active = 1'b0;
      tick();
      // asynchronous reset mid-SEND
      begin_stage(8'h20, 16'd64, 16'd64);
      bus.transaction_active = 1'b1;
      byte_step(8'h20, 1'b1);
      chk("pre_rst_valid", bus.data_in_valid, 1);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_valid", bus.data_in_valid, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_done", done, 0);
      bus.transaction_active = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      chk("rst_mid_done2", done, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
